// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Optional feature macro: ALU_STICKY_OVF_EN (sticky overflow in the PSR).
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int TAG_W     = 3;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef logic [3:0] alu_flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between adder, result stage and writeback.
// Optional feature macro: ALU_STICKY_OVF_EN (not used here).
interface alu_result_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = alu_pkg::TAG_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic             in_carry;
  logic             in_overflow;
  logic [TAG_W-1:0] in_dst;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_dst;
  alu_flags_t       out_flags;

  modport master (
    output in_valid, in_s, in_carry,
    output in_overflow, in_dst,
    input  in_ready,
    input  out_valid, out_result,
    input  out_dst, out_flags,
    output out_ready
  );

  modport slave (
    input  in_valid, in_s, in_carry,
    input  in_overflow, in_dst,
    output in_ready,
    output out_valid, out_result,
    output out_dst, out_flags,
    input  out_ready
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Derives N/Z/C/V from an adder result; purely combinational.
// Optional feature macro: ALU_STICKY_OVF_EN (not used here).
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] s,
  input  logic             carry,
  input  logic             overflow,
  output alu_flags_t       flags
);

  always_comb begin
    flags        = '0;
    flags[FLG_N] = s[WIDTH-1];
    flags[FLG_Z] = (s == '0);
    flags[FLG_C] = carry;
    flags[FLG_V] = overflow;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer between adder and writeback; owns the PSR.
// Optional feature macro: ALU_STICKY_OVF_EN (sticky V, cleared by flag_clr).
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = alu_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus,
  input  logic               flag_clr,
  output alu_flags_t         psr,
  output logic [1:0]         occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] dst;
    alu_flags_t       flags;
  } entry_t;

  stage_state_t state_q, state_d;
  entry_t       head_q, skid_q, new_e;
  alu_flags_t   new_flags;
  logic         push, pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .s        (bus.in_s),
    .carry    (bus.in_carry),
    .overflow (bus.in_overflow),
    .flags    (new_flags)
  );

  assign new_e = '{res: bus.in_s, dst: bus.in_dst,
                   flags: new_flags};

  // Both handshake outputs depend only on the state register.
  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign bus.out_result = head_q.res;
  assign bus.out_dst    = head_q.dst;
  assign bus.out_flags  = head_q.flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    occupancy = 2'd0;
    unique case (state_q)
      EMPTY: begin
        occupancy = 2'd0;
        if (push) state_d = ONE;
      end
      ONE: begin
        occupancy = 2'd1;
        if (push && !pop)      state_d = TWO;
        else if (pop && !push) state_d = EMPTY;
      end
      TWO: begin
        occupancy = 2'd2;
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: if (push) head_q <= new_e;
        ONE: begin
          if (push && pop)  head_q <= new_e;
          else if (push)    skid_q <= new_e;
        end
        TWO: if (pop) head_q <= skid_q;
        default: ;
      endcase
    end
  end

`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr <= '0;
    end else if (pop) begin
      psr[FLG_N] <= head_q.flags[FLG_N];
      psr[FLG_Z] <= head_q.flags[FLG_Z];
      psr[FLG_C] <= head_q.flags[FLG_C];
      psr[FLG_V] <= (flag_clr ? 1'b0 : psr[FLG_V])
                  | head_q.flags[FLG_V];
    end else if (flag_clr) begin
      psr[FLG_V] <= 1'b0;
    end
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   psr <= '0;
    else if (pop) psr <= head_q.flags;
  end
`endif

endmodule
